// File: rtl/dff_chk_pkg.sv
// ---------------------------------------------------------------------------
// dff_chk_pkg
// Shared types and helpers for the D flip-flop response checker.
//   state_t  - checker FSM states (2-bit encoding)
//   DEF_CNT_W - default width of the checker counters
//   sat_inc  - saturating increment used by every counter
// ---------------------------------------------------------------------------
package dff_chk_pkg;

    // The ST_ prefix keeps the state names apart from the WARMUP parameter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 16;

    // Returns val+1, or val unchanged once it has reached max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dff_ref_model.sv
// ---------------------------------------------------------------------------
// dff_ref_model
// One-cycle reference model of a D flip-flop with synchronous preset/clear
// (clear wins), plus detection of preset and clear asserted together.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   upd         - model samples the stimulus on this edge
//   arm         - the checker will be in CHECK after this edge
//   d, pre, clr - flip-flop stimulus copy (pre/clr active-high)
//   exp_q       - predicted q for the next edge
//   exp_valid   - exp_q may be compared on the next edge
//   conflict    - one-cycle pulse: pre and clr sampled high together
// ---------------------------------------------------------------------------
module dff_ref_model (
    input  logic clk,
    input  logic rst_n,
    input  logic upd,
    input  logic arm,
    input  logic d,
    input  logic pre,
    input  logic clr,
    output logic exp_q,
    output logic exp_valid,
    output logic conflict
);

    logic both;
    assign both = pre & clr;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
            conflict  <= 1'b0;
        end else if (upd) begin
            exp_q     <= clr ? 1'b0 : (pre ? 1'b1 : d);
            // A conflicting sample is not trusted: the following compare
            // is skipped.
            exp_valid <= arm & ~both;
            conflict  <= both;
        end else begin
            // Idle or halted: exp_q holds, nothing is armed.
            exp_valid <= 1'b0;
            conflict  <= 1'b0;
        end
    end

endmodule

// File: rtl/dff_checker.sv
// ---------------------------------------------------------------------------
// dff_checker
// Response checker for a D flip-flop with preset/clear. Watches the same
// stimulus as the flip-flop, predicts q one cycle ahead and counts
// mismatches.
// Parameters:
//   CNT_W       - width of all counters (saturating)
//   WARMUP      - model-only edges after enable before compares start
//   STOP_ON_ERR - 1: freeze in HALT at the first mismatch
// Build option:
//   DFF_CHK_COMPL_EN - when defined, qn is also checked against ~exp_q;
//                      otherwise qn is ignored.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   en             - checking enable
//   d, pre, clr    - stimulus copy; q, qn - flip-flop outputs
//   exp_q          - model prediction for the next compare
//   err            - one-cycle pulse per mismatch
//   err_sticky     - set on first mismatch, cleared by reset only
//   conflict       - pulse when pre and clr were sampled high together
//   mismatch_cnt   - saturating mismatch count
//   check_cnt      - saturating compare count
//   first_err_at   - check_cnt value at the first mismatch
//   halted         - high in HALT
// ---------------------------------------------------------------------------
module dff_checker
    import dff_chk_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WARMUP      = 2,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    input  logic             pre,
    input  logic             clr,
    input  logic             q,
    input  logic             qn,
    output logic             exp_q,
    output logic             err,
    output logic             err_sticky,
    output logic             conflict,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] first_err_at,
    output logic             halted
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Warm-up counter runs 0 .. WARMUP-1.
    localparam int WW          = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int WARM_LAST_I = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam logic [WW-1:0] WARM_LAST = WW'(WARM_LAST_I);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), 32'(CNT_MAX)));
    endfunction

    state_t          state, next_state;
    logic [WW-1:0]   warm_cnt, warm_next;
    logic            exp_valid;
    logic            upd, arm;
    logic            do_cmp, bad, miss;

    dff_ref_model u_model (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd       (upd),
        .arm       (arm),
        .d         (d),
        .pre       (pre),
        .clr       (clr),
        .exp_q     (exp_q),
        .exp_valid (exp_valid),
        .conflict  (conflict)
    );

`ifdef DFF_CHK_COMPL_EN
    assign bad = (q != exp_q) || (qn != ~exp_q);
`else
    logic unused_qn;
    assign unused_qn = qn;
    assign bad = (q != exp_q);
`endif

    // Dropping en disables the compare on that same edge.
    assign do_cmp = (state == ST_CHECK) && en && exp_valid;
    assign miss   = do_cmp && bad;

    // The model samples on every enabled edge except while halted, so the
    // enabling edge already produces a prediction (needed for WARMUP=0).
    assign upd = en && (state != ST_HALT);
    assign arm = (next_state == ST_CHECK);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        warm_next  = warm_cnt;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    warm_next  = '0;
                    next_state = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (!en)                         next_state = ST_IDLE;
                else if (warm_cnt == WARM_LAST)  next_state = ST_CHECK;
                else                             warm_next  = warm_cnt + 1'b1;
            end
            ST_CHECK: begin
                if (!en)                              next_state = ST_IDLE;
                else if ((STOP_ON_ERR != 0) && miss)  next_state = ST_HALT;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            warm_cnt     <= '0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            mismatch_cnt <= '0;
            check_cnt    <= '0;
            first_err_at <= '0;
        end else begin
            state    <= next_state;
            warm_cnt <= warm_next;
            err      <= miss;
            if (do_cmp) begin
                check_cnt <= bump(check_cnt);
            end
            if (miss) begin
                mismatch_cnt <= bump(mismatch_cnt);
                err_sticky   <= 1'b1;
                // Capture the count of compares completed before this one.
                if (!err_sticky) begin
                    first_err_at <= check_cnt;
                end
            end
        end
    end

    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_dff_checker.sv
// ---------------------------------------------------------------------------
// tb_dff_checker
// Self-checking bench for dff_checker. Three instances share one stimulus
// stream and one behavioural flip-flop, each with its own fault injection:
//   u_main : CNT_W=16, WARMUP=2, STOP_ON_ERR=0
//   u_halt : CNT_W=16, WARMUP=1, STOP_ON_ERR=1
//   u_sat  : CNT_W=4,  WARMUP=0, STOP_ON_ERR=0
// The reference model counts consecutive enabled edges and derives compare
// points, predictions and counters from that, with plain integer arithmetic.
// Honours DFF_CHK_COMPL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dff_checker;
    import dff_chk_pkg::*;

`ifdef DFF_CHK_COMPL_EN
    localparam bit COMPL_EN = 1'b1;
`else
    localparam bit COMPL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, d, pre, clr;
    logic [2:0] inj;
    logic       qn_stuck;
    logic       ff_q = 1'b0;

    // Behavioural flip-flop under check: synchronous clear beats preset.
    always @(posedge clk) ff_q <= clr ? 1'b0 : (pre ? 1'b1 : d);

    logic q0, q1, q2, qn0, qn1, qn2;
    assign q0  = ff_q ^ inj[0];
    assign q1  = ff_q ^ inj[1];
    assign q2  = ff_q ^ inj[2];
    assign qn0 = qn_stuck ? q0 : ~q0;
    assign qn1 = qn_stuck ? q1 : ~q1;
    assign qn2 = qn_stuck ? q2 : ~q2;

    logic        eq0, er0, st0, cf0, hl0;
    logic [15:0] mc0, cc0, fe0;
    logic        eq1, er1, st1, cf1, hl1;
    logic [15:0] mc1, cc1, fe1;
    logic        eq2, er2, st2, cf2, hl2;
    logic [3:0]  mc2, cc2, fe2;

    dff_checker #(.CNT_W(16), .WARMUP(2), .STOP_ON_ERR(0)) u_main (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .pre(pre), .clr(clr),
        .q(q0), .qn(qn0), .exp_q(eq0), .err(er0), .err_sticky(st0),
        .conflict(cf0), .mismatch_cnt(mc0), .check_cnt(cc0),
        .first_err_at(fe0), .halted(hl0)
    );

    dff_checker #(.CNT_W(16), .WARMUP(1), .STOP_ON_ERR(1)) u_halt (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .pre(pre), .clr(clr),
        .q(q1), .qn(qn1), .exp_q(eq1), .err(er1), .err_sticky(st1),
        .conflict(cf1), .mismatch_cnt(mc1), .check_cnt(cc1),
        .first_err_at(fe1), .halted(hl1)
    );

    dff_checker #(.CNT_W(4), .WARMUP(0), .STOP_ON_ERR(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .pre(pre), .clr(clr),
        .q(q2), .qn(qn2), .exp_q(eq2), .err(er2), .err_sticky(st2),
        .conflict(cf2), .mismatch_cnt(mc2), .check_cnt(cc2),
        .first_err_at(fe2), .halted(hl2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int warm;       // WARMUP parameter
        int maxv;       // counter saturation value
        bit stop;       // STOP_ON_ERR
        int run;        // consecutive enabled edges so far (capped)
        bit prev_conf;  // previous enabled edge saw pre & clr
        bit exp_q;
        bit err;
        bit sticky;
        bit conflict;
        bit halted;
        int mcnt;
        int ccnt;
        int first;
    } mdl_t;

    mdl_t m[3];

    function automatic int sat(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Effect of one clock edge given the values sampled at that edge.
    function automatic mdl_t step(mdl_t s, bit rn, bit e, bit dd, bit p,
                                  bit c, bit qq, bit qqn);
        bit bad;
        if (!rn) begin
            s.run = 0; s.prev_conf = 0; s.exp_q = 0; s.err = 0;
            s.sticky = 0; s.conflict = 0; s.halted = 0;
            s.mcnt = 0; s.ccnt = 0; s.first = 0;
            return s;
        end
        s.err = 0;
        s.conflict = 0;
        if (s.halted) return s;
        if (!e) begin
            s.run = 0;
            s.prev_conf = 0;
            return s;
        end
        // Compares start on enabled edge number WARMUP+1 (enabling edge = 0).
        if (s.run > s.warm && !s.prev_conf) begin
            bad = (qq != s.exp_q);
            if (COMPL_EN && (qqn == s.exp_q)) bad = 1'b1;
            if (bad && !s.sticky) s.first = s.ccnt;
            s.ccnt = sat(s.ccnt, s.maxv);
            if (bad) begin
                s.err = 1;
                s.sticky = 1;
                s.mcnt = sat(s.mcnt, s.maxv);
                if (s.stop) s.halted = 1;
            end
        end
        s.exp_q = c ? 1'b0 : (p ? 1'b1 : dd);
        s.conflict = p && c;
        s.prev_conf = p && c;
        if (s.run <= s.warm) s.run++;
        return s;
    endfunction

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string n, input int i, input logic eq,
                              input logic er, input logic st, input logic cf,
                              input logic hl, input logic [31:0] mc,
                              input logic [31:0] cc, input logic [31:0] fe);
        check({n, ".exp_q"},        32'(eq), 32'(m[i].exp_q));
        check({n, ".err"},          32'(er), 32'(m[i].err));
        check({n, ".err_sticky"},   32'(st), 32'(m[i].sticky));
        check({n, ".conflict"},     32'(cf), 32'(m[i].conflict));
        check({n, ".halted"},       32'(hl), 32'(m[i].halted));
        check({n, ".mismatch_cnt"}, mc,      32'(m[i].mcnt));
        check({n, ".check_cnt"},    cc,      32'(m[i].ccnt));
        check({n, ".first_err_at"}, fe,      32'(m[i].first));
    endtask

    // Called at a negedge with inputs already driven: steps the models with
    // the values the next rising edge will sample, then checks after it.
    task automatic cycle();
        #1;
        m[0] = step(m[0], rst_n, en, d, pre, clr, q0, qn0);
        m[1] = step(m[1], rst_n, en, d, pre, clr, q1, qn1);
        m[2] = step(m[2], rst_n, en, d, pre, clr, q2, qn2);
        @(posedge clk);
        @(negedge clk);
        check_inst("main", 0, eq0, er0, st0, cf0, hl0, 32'(mc0), 32'(cc0), 32'(fe0));
        check_inst("halt", 1, eq1, er1, st1, cf1, hl1, 32'(mc1), 32'(cc1), 32'(fe1));
        check_inst("sat",  2, eq2, er2, st2, cf2, hl2, 32'(mc2), 32'(cc2), 32'(fe2));
    endtask

    initial begin
        int errs;
        int saved;

        for (int i = 0; i < 3; i++) begin
            m[i] = '{default: 0};
        end
        m[0].warm = 2; m[0].maxv = 65535; m[0].stop = 0;
        m[1].warm = 1; m[1].maxv = 65535; m[1].stop = 1;
        m[2].warm = 0; m[2].maxv = 15;    m[2].stop = 0;

        rst_n = 0; en = 0; d = 0; pre = 0; clr = 0; inj = '0; qn_stuck = 0;
        @(negedge clk);
        cycle();
        cycle();
        check("reset.main.check_cnt", 32'(cc0), 0);
        check("reset.halt.halted",    32'(hl1), 0);

        // Clean run: enabling edge, then 40 cycles with d toggling every 3.
        rst_n = 1;
        en = 1;
        cycle();
        for (int k = 0; k < 40; k++) begin
            d = ((k / 3) % 2) != 0;
            cycle();
        end
        check("clean.check_cnt",    32'(cc0), 38);
        check("clean.mismatch_cnt", 32'(mc0), 0);
        check("clean.err_sticky",   32'(st0), 0);

        // Single corrupted q at the 10th compare.
        rst_n = 0; en = 0;
        cycle();
        rst_n = 1; en = 1;
        cycle();
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            d = ((k / 3) % 2) != 0;
            inj[0] = (m[0].ccnt == 9);
            cycle();
            errs += int'(er0);
        end
        inj = '0;
        check("inject.err_pulses",   32'(errs), 1);
        check("inject.mismatch_cnt", 32'(mc0), 1);
        check("inject.first_err_at", 32'(fe0), 9);
        check("inject.err_sticky",   32'(st0), 1);

        // Clear then preset, then both together.
        d = 1; clr = 1; pre = 0;
        cycle();
        check("clr.exp_q", 32'(eq0), 0);
        d = 0; clr = 0; pre = 1;
        cycle();
        check("pre.exp_q", 32'(eq0), 1);
        clr = 1; pre = 1;
        cycle();
        check("both.conflict", 32'(cf0), 1);
        saved = m[0].ccnt;
        clr = 0; pre = 0;
        cycle();
        check("both.skip_check_cnt", 32'(cc0), 32'(saved));
        check("both.mismatch_cnt",   32'(mc0), 1);

        // Randomised traffic with occasional enable drops and injected faults.
        for (int k = 0; k < 300; k++) begin
            en  = ($urandom_range(0, 15) != 0);
            d   = $urandom_range(0, 1) != 0;
            pre = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 3; i++) begin
                inj[i] = ($urandom_range(0, 11) == 0);
            end
            cycle();
        end

        // Guaranteed halt on u_halt, then 20 frozen cycles.
        en = 1; pre = 0; clr = 0; inj = '0;
        for (int k = 0; k < 5; k++) begin
            d = $urandom_range(0, 1) != 0;
            cycle();
        end
        inj[1] = 1'b1;
        cycle();
        inj = '0;
        saved = m[1].ccnt;
        for (int k = 0; k < 20; k++) begin
            d   = $urandom_range(0, 1) != 0;
            pre = ($urandom_range(0, 7) == 0);
            cycle();
        end
        pre = 0;
        check("halt.halted",         32'(hl1), 1);
        check("halt.frozen_checks",  32'(cc1), 32'(saved));

        // Permanently wrong q on the 4-bit instance.
        cycle();
        errs = 0;
        inj[2] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            d = $urandom_range(0, 1) != 0;
            cycle();
            errs += int'(er2);
        end
        inj = '0;
        check("sat.mismatch_cnt", 32'(mc2), 15);
        check("sat.err_pulses",   32'(errs), 40);

        // qn stuck at q: only counts as an error when qn is checked.
        saved = m[0].mcnt;
        qn_stuck = 1;
        for (int k = 0; k < 10; k++) begin
            d = $urandom_range(0, 1) != 0;
            cycle();
        end
        qn_stuck = 0;
        check("qn_stuck.mismatch_cnt", 32'(mc0), 32'(saved + (COMPL_EN ? 10 : 0)));

        // One reset edge clears everything, including HALT.
        rst_n = 0;
        cycle();
        check("final_rst.halted",       32'(hl1), 0);
        check("final_rst.state",        32'(u_halt.state), 32'(ST_IDLE));
        check("final_rst.mismatch_cnt", 32'(mc0), 0);
        check("final_rst.err_sticky",   32'(st0), 0);
        rst_n = 1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
